// File: rtl/pe_conv_engine_if.sv
// Handshake bundle for pe_conv_engine: memory writes, start, psum in/out, status.
// slave = engine side, master = depacketizer/packetizer side.
interface pe_conv_engine_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PSUM_W = 16,
  parameter int unsigned ADDR_W = 3
);
  logic              wr_valid;
  logic              wr_ready;
  logic              wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start_valid;
  logic              start_ready;
  logic              start_acc;
  logic              psum_in_valid;
  logic              psum_in_ready;
  logic [PSUM_W-1:0] psum_in_data;
  logic              psum_out_valid;
  logic              psum_out_ready;
  logic [PSUM_W-1:0] psum_out_data;
  logic              busy;
  logic              done;

  modport slave (
    input  wr_valid, wr_sel, wr_addr, wr_data,
    input  start_valid, start_acc,
    input  psum_in_valid, psum_in_data,
    input  psum_out_ready,
    output wr_ready, start_ready, psum_in_ready,
    output psum_out_valid, psum_out_data, busy, done
  );

  modport master (
    output wr_valid, wr_sel, wr_addr, wr_data,
    output start_valid, start_acc,
    output psum_in_valid, psum_in_data,
    output psum_out_ready,
    input  wr_ready, start_ready, psum_in_ready,
    input  psum_out_valid, psum_out_data, busy, done
  );
endinterface

// File: rtl/pe_conv_engine.sv
// 1-D sliding-window convolution engine for a NoC PE: local ifmap/filter RFs, one psum per window.
// Optional macro PE_PSUM_SAT_EN: every accumulation saturates at 2^PSUM_W-1 instead of wrapping.
module pe_conv_engine #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned PSUM_W  = 16,
  parameter int unsigned DEPTH_I = 8,
  parameter int unsigned DEPTH_F = 3,
  parameter int unsigned STRIDE  = 1,
  parameter int unsigned ADDR_W  = $clog2(DEPTH_I)
) (
  input logic             clk,
  input logic             rst_n,
  pe_conv_engine_if.slave bus
);

  localparam int unsigned N_OUT  = (DEPTH_I - DEPTH_F) / STRIDE + 1;
  localparam int unsigned IDX_W  = (DEPTH_I > 1) ? $clog2(DEPTH_I) : 1;
  localparam int unsigned TAP_W  = (DEPTH_F > 1) ? $clog2(DEPTH_F) : 1;
  localparam int unsigned WIN_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int unsigned PROD_W = 2 * DATA_W;

  typedef enum logic [2:0] {IDLE, MAC, ADDPS, OUT, DONE} state_t;

  state_t            state;
  logic [WIN_W-1:0]  win_idx;
  logic [TAP_W-1:0]  tap;
  logic [PSUM_W-1:0] acc;
  logic              acc_mode;
  logic [DATA_W-1:0] ifmap  [DEPTH_I];
  logic [DATA_W-1:0] filter [DEPTH_F];

  logic [IDX_W-1:0]  rd_idx_c;
  logic [PROD_W-1:0] prod_c;
  logic [PSUM_W-1:0] mac_sum_c;
  logic [PSUM_W-1:0] ps_sum_c;
  logic              wr_fire_c;
  logic              start_fire_c;
  logic              wr_in_range_c;

  function automatic logic [PSUM_W-1:0] psum_add(input logic [PSUM_W-1:0] a,
                                                 input logic [PSUM_W-1:0] b);
`ifdef PE_PSUM_SAT_EN
    logic [PSUM_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[PSUM_W] ? {PSUM_W{1'b1}} : s[PSUM_W-1:0];
`else
    return a + b;
`endif
  endfunction

  // Current tap product and the two candidate accumulator updates.
  always_comb begin
    rd_idx_c      = IDX_W'(32'(win_idx) * STRIDE + 32'(tap));
    prod_c        = PROD_W'(ifmap[rd_idx_c]) * PROD_W'(filter[tap]);
    mac_sum_c     = psum_add(acc, PSUM_W'(prod_c));
    ps_sum_c      = psum_add(acc, bus.psum_in_data);
    wr_fire_c     = bus.wr_valid && bus.wr_ready;
    start_fire_c  = bus.start_valid && bus.start_ready;
    wr_in_range_c = bus.wr_sel ? (32'(bus.wr_addr) < DEPTH_F) : (32'(bus.wr_addr) < DEPTH_I);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      win_idx            <= '0;
      tap                <= '0;
      acc                <= '0;
      acc_mode           <= 1'b0;
      for (int i = 0; i < int'(DEPTH_I); i++) ifmap[i] <= '0;
      for (int i = 0; i < int'(DEPTH_F); i++) filter[i] <= '0;
      bus.wr_ready       <= 1'b1;
      bus.start_ready    <= 1'b1;
      bus.psum_in_ready  <= 1'b0;
      bus.psum_out_valid <= 1'b0;
      bus.psum_out_data  <= '0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          // A write coinciding with start lands before the first MAC reads memory.
          if (wr_fire_c && wr_in_range_c) begin
            if (bus.wr_sel) filter[TAP_W'(bus.wr_addr)] <= bus.wr_data;
            else            ifmap[IDX_W'(bus.wr_addr)]  <= bus.wr_data;
          end
          if (start_fire_c) begin
            acc_mode        <= bus.start_acc;
            win_idx         <= '0;
            tap             <= '0;
            acc             <= '0;
            bus.wr_ready    <= 1'b0;
            bus.start_ready <= 1'b0;
            bus.busy        <= 1'b1;
            state           <= MAC;
          end
        end
        MAC: begin
          acc <= mac_sum_c;
          tap <= tap + TAP_W'(1);
          if (tap == TAP_W'(DEPTH_F - 1)) begin
            if (acc_mode) begin
              bus.psum_in_ready <= 1'b1;
              state             <= ADDPS;
            end else begin
              bus.psum_out_valid <= 1'b1;
              bus.psum_out_data  <= mac_sum_c;
              state              <= OUT;
            end
          end
        end
        ADDPS: begin
          if (bus.psum_in_valid && bus.psum_in_ready) begin
            acc                <= ps_sum_c;
            bus.psum_in_ready  <= 1'b0;
            bus.psum_out_valid <= 1'b1;
            bus.psum_out_data  <= ps_sum_c;
            state              <= OUT;
          end
        end
        OUT: begin
          if (bus.psum_out_valid && bus.psum_out_ready) begin
            bus.psum_out_valid <= 1'b0;
            if (win_idx == WIN_W'(N_OUT - 1)) begin
              bus.done <= 1'b1;
              state    <= DONE;
            end else begin
              win_idx <= win_idx + WIN_W'(1);
              tap     <= '0;
              acc     <= '0;
              state   <= MAC;
            end
          end
        end
        DONE: begin
          bus.wr_ready    <= 1'b1;
          bus.start_ready <= 1'b1;
          bus.busy        <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_conv_engine.sv
// Bench for pe_conv_engine: STRIDE=1 and STRIDE=2 instances driven in lockstep,
// results compared against a window-sum reference model.
module tb_pe_conv_engine;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned PSUM_W  = 16;
  localparam int unsigned DEPTH_I = 8;
  localparam int unsigned DEPTH_F = 3;
  localparam int unsigned ADDR_W  = 3;
  localparam longint      PSUM_MAX = (longint'(1) << PSUM_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pe_conv_engine_if #(.DATA_W(DATA_W), .PSUM_W(PSUM_W), .ADDR_W(ADDR_W)) bus1 ();
  pe_conv_engine_if #(.DATA_W(DATA_W), .PSUM_W(PSUM_W), .ADDR_W(ADDR_W)) bus2 ();

  pe_conv_engine #(.DATA_W(DATA_W), .PSUM_W(PSUM_W), .DEPTH_I(DEPTH_I), .DEPTH_F(DEPTH_F),
                   .STRIDE(1), .ADDR_W(ADDR_W))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  pe_conv_engine #(.DATA_W(DATA_W), .PSUM_W(PSUM_W), .DEPTH_I(DEPTH_I), .DEPTH_F(DEPTH_F),
                   .STRIDE(2), .ADDR_W(ADDR_W))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  assign bus2.wr_valid       = bus1.wr_valid;
  assign bus2.wr_sel         = bus1.wr_sel;
  assign bus2.wr_addr        = bus1.wr_addr;
  assign bus2.wr_data        = bus1.wr_data;
  assign bus2.start_valid    = bus1.start_valid;
  assign bus2.start_acc      = bus1.start_acc;
  assign bus2.psum_in_valid  = bus1.psum_in_valid;
  assign bus2.psum_in_data   = bus1.psum_in_data;
  assign bus2.psum_out_ready = bus1.psum_out_ready;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int unsigned       mi [DEPTH_I];
  int unsigned       mf [DEPTH_F];
  logic [PSUM_W-1:0] q1 [$];
  logic [PSUM_W-1:0] q2 [$];
  int                h1 [$];
  int                dq1 [$];
  int                dn2 = 0;

  int                start_cyc = 0;
  bit                rdy_rand  = 1'b0;
  logic              rdy_level = 1'b1;
  int                psum_delay = 2;
  logic [PSUM_W-1:0] psum_val  = '0;
  int                b1, b2, d1, d2;

  // Output monitor: handshakes are sampled mid-cycle and complete on the next rising edge.
  always @(negedge clk) begin
    if (bus1.psum_out_valid && bus1.psum_out_ready) begin
      q1.push_back(bus1.psum_out_data);
      h1.push_back(cyc);
    end
    if (bus2.psum_out_valid && bus2.psum_out_ready) q2.push_back(bus2.psum_out_data);
    if (bus1.done) dq1.push_back(cyc);
    if (bus2.done) dn2++;
  end

  initial begin
    bus1.psum_out_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      bus1.psum_out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_level;
    end
  end

  // Upstream psum source: raises valid psum_delay cycles after psum_in_ready is seen.
  initial begin
    int dly;
    dly = 0;
    bus1.psum_in_valid = 1'b0;
    bus1.psum_in_data  = '0;
    forever begin
      @(posedge clk); #2;
      bus1.psum_in_data = psum_val;
      if (!rst_n) begin
        bus1.psum_in_valid = 1'b0;
        dly = 0;
      end else if (bus1.psum_in_valid) begin
        if (!bus1.psum_in_ready) bus1.psum_in_valid = 1'b0;
      end else if (bus1.psum_in_ready) begin
        dly++;
        if (dly > psum_delay) begin
          bus1.psum_in_valid = 1'b1;
          dly = 0;
        end
      end else begin
        dly = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before timeout");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int nout(input int stride);
    return (int'(DEPTH_I) - int'(DEPTH_F)) / stride + 1;
  endfunction

  // Reference: plain dot product of the window plus optional psum, then wrap or clamp.
  function automatic longint ref_win(input int stride, input int w, input bit use_acc,
                                     input longint psum);
    longint t;
    t = 0;
    for (int k = 0; k < int'(DEPTH_F); k++)
      t += longint'(mi[w * stride + k]) * longint'(mf[k]);
    if (use_acc) t += psum;
`ifdef PE_PSUM_SAT_EN
    if (t > PSUM_MAX) t = PSUM_MAX;
`else
    t = t % (PSUM_MAX + 1);
`endif
    return t;
  endfunction

  task automatic wr(input bit sel, input int addr, input int data);
    bus1.wr_valid = 1'b1;
    bus1.wr_sel   = sel;
    bus1.wr_addr  = ADDR_W'(addr);
    bus1.wr_data  = DATA_W'(data);
    @(posedge clk); #1;
    bus1.wr_valid = 1'b0;
    if (!sel && addr < int'(DEPTH_I)) mi[addr] = int'(data % 256);
    else if (sel && addr < int'(DEPTH_F)) mf[addr] = int'(data % 256);
  endtask

  task automatic load(input int kind);
    for (int i = 0; i < int'(DEPTH_I); i++)
      wr(1'b0, i, (kind == 0) ? i + 1 : (kind == 1) ? 255 : int'($urandom_range(0, 255)));
    for (int k = 0; k < int'(DEPTH_F); k++)
      wr(1'b1, k, (kind == 0) ? k + 1 : (kind == 1) ? 255 : int'($urandom_range(0, 255)));
  endtask

  task automatic start(input bit use_acc, input bit with_wr, input int addr, input int data);
    b1 = q1.size();
    b2 = q2.size();
    d1 = dq1.size();
    d2 = dn2;
    bus1.start_valid = 1'b1;
    bus1.start_acc   = use_acc;
    if (with_wr) begin
      bus1.wr_valid = 1'b1;
      bus1.wr_sel   = 1'b0;
      bus1.wr_addr  = ADDR_W'(addr);
      bus1.wr_data  = DATA_W'(data);
    end
    @(posedge clk); #1;
    start_cyc        = cyc;
    bus1.start_valid = 1'b0;
    bus1.wr_valid    = 1'b0;
    if (with_wr) mi[addr] = int'(data % 256);
  endtask

  task automatic wait_done(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (dq1.size() > d1) break;
      @(posedge clk); #1;
    end
    chk({tag, " completes"}, 64'(dq1.size() > d1), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_run(input string tag, input bit use_acc, input longint psum);
    chk({tag, " s1 count"}, q1.size() - b1, nout(1));
    for (int i = 0; i < nout(1) && b1 + i < q1.size(); i++)
      chk($sformatf("%s s1 win%0d", tag, i), q1[b1 + i], ref_win(1, i, use_acc, psum));
    chk({tag, " s2 count"}, q2.size() - b2, nout(2));
    for (int i = 0; i < nout(2) && b2 + i < q2.size(); i++)
      chk($sformatf("%s s2 win%0d", tag, i), q2[b2 + i], ref_win(2, i, use_acc, psum));
    chk({tag, " s1 done pulses"}, dq1.size() - d1, 1);
    chk({tag, " s2 done pulses"}, dn2 - d2, 1);
  endtask

  initial begin
    bit ua;
    bus1.wr_valid    = 1'b0;
    bus1.wr_sel      = 1'b0;
    bus1.wr_addr     = '0;
    bus1.wr_data     = '0;
    bus1.start_valid = 1'b0;
    bus1.start_acc   = 1'b0;
    for (int i = 0; i < int'(DEPTH_I); i++) mi[i] = 0;
    for (int k = 0; k < int'(DEPTH_F); k++) mf[k] = 0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset wr_ready", bus1.wr_ready, 1);
    chk("reset start_ready", bus1.start_ready, 1);
    chk("reset busy", bus1.busy, 0);
    chk("reset psum_out_valid", bus1.psum_out_valid, 0);
    chk("reset psum_in_ready", bus1.psum_in_ready, 0);
    chk("reset done", bus1.done, 0);
    chk("reset psum_out_data", bus1.psum_out_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic convolution with timing checks
    load(0);
    rdy_level = 1'b1;
    start(1'b0, 1'b0, 0, 0);
    wait_done(200, "basic");
    check_run("basic", 1'b0, 0);
    if (q1.size() > b1 + 1) begin
      chk("basic first valid latency", h1[b1] - start_cyc, DEPTH_F);
      chk("basic window period", h1[b1 + 1] - h1[b1], DEPTH_F + 1);
    end
    if (dq1.size() > d1)
      chk("basic done cycle", dq1[d1] - start_cyc, nout(1) * (int'(DEPTH_F) + 1));

    // Psum add with delayed upstream valid
    psum_val   = 16'd100;
    psum_delay = 2;
    start(1'b1, 1'b0, 0, 0);
    wait_done(300, "psum");
    check_run("psum", 1'b1, 100);

    // Backpressure on window 0
    rdy_level = 1'b0;
    start(1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 50 && !bus1.psum_out_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("bp valid raised", bus1.psum_out_valid, 1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp valid held", bus1.psum_out_valid, 1);
      chk("bp data held", bus1.psum_out_data, ref_win(1, 0, 1'b0, 0));
      chk("bp no transfer", q1.size() - b1, 0);
      chk("bp s2 no transfer", q2.size() - b2, 0);
    end
    rdy_level = 1'b1;
    wait_done(200, "backpressure");
    check_run("backpressure", 1'b0, 0);

    // Start request while busy is ignored
    start(1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 100 && q1.size() == b1; i++) begin
      @(posedge clk); #1;
    end
    chk("busy start_ready", bus1.start_ready, 0);
    chk("busy flag", bus1.busy, 1);
    bus1.start_valid = 1'b1;
    bus1.start_acc   = 1'b1;
    @(posedge clk); #1;
    bus1.start_valid = 1'b0;
    wait_done(200, "ignored start");
    check_run("ignored start", 1'b0, 0);

    // Out-of-range filter write
    wr(1'b1, 5, 77);
    start(1'b0, 1'b0, 0, 0);
    wait_done(200, "filter addr 5");
    check_run("filter addr 5", 1'b0, 0);

    // Overflow: wrap or saturate
    load(1);
    start(1'b0, 1'b0, 0, 0);
    wait_done(200, "overflow");
    check_run("overflow", 1'b0, 0);
    psum_val   = 16'd1000;
    psum_delay = 0;
    start(1'b1, 1'b0, 0, 0);
    wait_done(300, "overflow psum");
    check_run("overflow psum", 1'b1, 1000);

    // Random data, random ready, write coinciding with start
    for (int r = 0; r < 4; r++) begin
      load(2);
      rdy_rand   = 1'b1;
      psum_val   = PSUM_W'($urandom);
      psum_delay = int'($urandom_range(0, 3));
      ua         = 1'($urandom_range(0, 1));
      start(ua, 1'b1, int'($urandom_range(0, DEPTH_I - 1)), int'($urandom_range(0, 255)));
      wait_done(800, $sformatf("rand%0d", r));
      check_run($sformatf("rand%0d", r), ua, longint'(psum_val));
    end
    rdy_rand  = 1'b0;
    rdy_level = 1'b1;

    // Reset during MAC of window 2
    load(0);
    psum_val = '0;
    start(1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 200 && q1.size() - b1 < 2; i++) begin
      @(posedge clk); #1;
    end
    chk("abort reached window 2", q1.size() - b1, 2);
    chk("abort busy before reset", bus1.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort psum_out_valid", bus1.psum_out_valid, 0);
    chk("abort busy", bus1.busy, 0);
    chk("abort done", bus1.done, 0);
    chk("abort wr_ready", bus1.wr_ready, 1);
    chk("abort start_ready", bus1.start_ready, 1);
    for (int i = 0; i < int'(DEPTH_I); i++) mi[i] = 0;
    for (int k = 0; k < int'(DEPTH_F); k++) mf[k] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort no done", dq1.size() - d1, 0);
    chk("abort no further outputs", q1.size() - b1, 2);
    rst_n = 1'b1;
    @(posedge clk); #1;
    start(1'b0, 1'b0, 0, 0);
    wait_done(200, "after reset");
    check_run("after reset", 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
